// File: rtl/decode_block.sv
// Decode stage for the 16-bit MIPS pipeline: register file, pending-write scoreboard, operand issue.
// Optional macro DECODE_WB_BYPASS_EN forwards same-cycle write-back into reads and hazard checks.
module decode_block #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       instr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              wb_en,
    input  logic [2:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [5:0]        op_dec,
    output logic [2:0]        rd_out,
    output logic              out_valid
);

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   pending_nxt;
    logic [NREG-1:0]   pend_eff;

    logic [5:0]        opcode;
    logic [2:0]        rd;
    logic [2:0]        rs;
    logic [2:0]        rt;
    logic              r_type;
    logic              hazard;
    logic              issue;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] b_val;

    assign opcode = instr[15:10];
    assign rd     = instr[9:7];
    assign rs     = instr[6:4];
    assign rt     = instr[3:1];
    assign r_type = ~opcode[5];

    always_comb begin
        pend_eff = pending;
`ifdef DECODE_WB_BYPASS_EN
        if (wb_en) pend_eff[wb_addr] = 1'b0;
`endif
    end

    // R0 is forced to zero after any forwarding so a write-back to R0 never leaks through
    always_comb begin
        rs_val = regs[rs];
        rt_val = regs[rt];
`ifdef DECODE_WB_BYPASS_EN
        if (wb_en && wb_addr == rs) rs_val = wb_data;
        if (wb_en && wb_addr == rt) rt_val = wb_data;
`endif
        if (rs == 3'd0) rs_val = '0;
        if (rt == 3'd0) rt_val = '0;
    end

    always_comb begin
        hazard   = pend_eff[rs] | (r_type & pend_eff[rt]) | ((rd != 3'd0) & pend_eff[rd]);
        in_ready = reset & ~hazard;
        issue    = in_valid & in_ready;
        b_val    = r_type ? rt_val : {{(DATA_W-4){instr[3]}}, instr[3:0]};
    end

    // Issue is applied after write-back so a same-edge set of the same bit wins
    always_comb begin
        pending_nxt = pending;
        if (wb_en) pending_nxt[wb_addr] = 1'b0;
        if (issue && rd != 3'd0) pending_nxt[rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            A         <= '0;
            B         <= '0;
            op_dec    <= '0;
            rd_out    <= '0;
            out_valid <= 1'b0;
            pending   <= '0;
            for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            out_valid <= issue;
            if (issue) begin
                A      <= rs_val;
                B      <= b_val;
                op_dec <= {1'b0, opcode[4:0]};
                rd_out <= rd;
            end
            pending <= pending_nxt;
            if (wb_en && wb_addr != 3'd0) regs[wb_addr] <= wb_data;
        end
    end

endmodule

// File: tb/tb_decode_block.sv
// Scoreboard bench for decode_block: directed issue/stall/write-back sequences, queued expectations.
module tb_decode_block;

    logic        clk;
    logic        reset;
    logic [15:0] instr;
    logic        in_valid;
    logic        in_ready;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic [15:0] A;
    logic [15:0] B;
    logic [5:0]  op_dec;
    logic [2:0]  rd_out;
    logic        out_valid;

    decode_block #(.DATA_W(16), .NREG(8)) dut (
        .clk(clk), .reset(reset), .instr(instr), .in_valid(in_valid), .in_ready(in_ready),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .A(A), .B(B), .op_dec(op_dec), .rd_out(rd_out), .out_valid(out_valid)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [5:0]  op;
        logic [2:0]  rd;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   total = 0;
    int   bad   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    task automatic load(input logic [15:0] ins, input logic [15:0] ea, input logic [15:0] eb,
                        input logic [5:0] eop, input logic [2:0] erd);
        instr    = ins;
        in_valid = 1'b1;
        cur      = '{a: ea, b: eb, op: eop, rd: erd};
    endtask

    task automatic idle();
        instr    = 16'h0000;
        in_valid = 1'b0;
    endtask

    task automatic set_wb(input logic en, input logic [2:0] a, input logic [15:0] d);
        wb_en   = en;
        wb_addr = a;
        wb_data = d;
    endtask

    task automatic step(input logic exp_rdy, input string nm);
        #1;
        chk({nm, "_rdy"}, {15'd0, in_ready}, {15'd0, exp_rdy});
        if (in_valid && exp_rdy) q.push_back(cur);
        @(negedge clk);
    endtask

    // Monitor: every issued instruction must match the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_issue: got A=%h B=%h op=%h rd=%h expected no issue", A, B, op_dec, rd_out);
                end else begin
                    e = q.pop_front();
                    chk("issue_A", A, e.a);
                    chk("issue_B", B, e.b);
                    chk("issue_op", {10'd0, op_dec}, {10'd0, e.op});
                    chk("issue_rd", {13'd0, rd_out}, {13'd0, e.rd});
                end
            end
        end
    end

    initial begin
        reset = 1'b1; in_valid = 1'b1; instr = 16'h0000;
        set_wb(1'b0, 3'd0, 16'h0000);
        #2 reset = 1'b0;
        #1;
        chk("rst_ready", {15'd0, in_ready}, 16'd0);
        chk("rst_ovalid", {15'd0, out_valid}, 16'd0);
        chk("rst_A", A, 16'h0000);
        chk("rst_B", B, 16'h0000);
        chk("rst_op", {10'd0, op_dec}, 16'd0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_hold_ready", {15'd0, in_ready}, 16'd0);
        chk("rst_hold_ovalid", {15'd0, out_valid}, 16'd0);
        reset = 1'b1;
        idle();
        step(1'b1, "idle");

        set_wb(1'b1, 3'd1, 16'h4000); step(1'b1, "wb_r1");
        set_wb(1'b1, 3'd2, 16'hC000); step(1'b1, "wb_r2");
        set_wb(1'b0, 3'd0, 16'h0000);

        load({6'd0, 3'd3, 3'd1, 3'd2, 1'b0}, 16'h4000, 16'hC000, 6'd0, 3'd3); step(1'b1, "rtype");
        load({6'd33, 3'd4, 3'd1, 4'hF}, 16'h4000, 16'hFFFF, 6'd1, 3'd4); step(1'b1, "itype");

        load({6'd34, 3'd5, 3'd3, 4'h1}, 16'h0008, 16'h0001, 6'd2, 3'd5);
        step(1'b0, "raw_s0");
        step(1'b0, "raw_s1");
        set_wb(1'b1, 3'd3, 16'h0008);
`ifdef DECODE_WB_BYPASS_EN
        step(1'b1, "raw_wb");
        set_wb(1'b0, 3'd0, 16'h0000);
`else
        step(1'b0, "raw_wb");
        set_wb(1'b0, 3'd0, 16'h0000);
        step(1'b1, "raw_go");
`endif

        load({6'd35, 3'd5, 3'd1, 4'h2}, 16'h4000, 16'h0002, 6'd3, 3'd5);
        step(1'b0, "waw_s0");
        set_wb(1'b1, 3'd5, 16'h0077);
`ifdef DECODE_WB_BYPASS_EN
        step(1'b1, "waw_wb");
        set_wb(1'b0, 3'd0, 16'h0000);
`else
        step(1'b0, "waw_wb");
        set_wb(1'b0, 3'd0, 16'h0000);
        step(1'b1, "waw_go");
`endif

        idle();
        set_wb(1'b1, 3'd0, 16'h1234); step(1'b1, "wb_r0");
        set_wb(1'b0, 3'd0, 16'h0000);
        load({6'd4, 3'd0, 3'd0, 3'd0, 1'b0}, 16'h0000, 16'h0000, 6'd4, 3'd0); step(1'b1, "r0_read");
        load({6'd5, 3'd7, 3'd0, 3'd0, 1'b0}, 16'h0000, 16'h0000, 6'd5, 3'd7); step(1'b1, "after_rd0");

        load({6'd36, 3'd6, 3'd2, 4'h8}, 16'hC000, 16'hFFF8, 6'd4, 3'd6);
        set_wb(1'b1, 3'd6, 16'h5555); step(1'b1, "setclr");
        set_wb(1'b0, 3'd0, 16'h0000);
        load({6'd6, 3'd0, 3'd6, 3'd1, 1'b0}, 16'h6666, 16'h4000, 6'd6, 3'd0);
        step(1'b0, "setclr_s0");
        step(1'b0, "setclr_s1");
        set_wb(1'b1, 3'd6, 16'h6666);
`ifdef DECODE_WB_BYPASS_EN
        step(1'b1, "setclr_wb");
        set_wb(1'b0, 3'd0, 16'h0000);
`else
        step(1'b0, "setclr_wb");
        set_wb(1'b0, 3'd0, 16'h0000);
        step(1'b1, "setclr_go");
`endif

        load({6'd7, 3'd0, 3'd4, 3'd1, 1'b0}, 16'h0000, 16'h0000, 6'd7, 3'd0);
        step(1'b0, "mid_stall");
        #2 reset = 1'b0;
        #1;
        chk("midrst_ready", {15'd0, in_ready}, 16'd0);
        chk("midrst_ovalid", {15'd0, out_valid}, 16'd0);
        chk("midrst_A", A, 16'h0000);
        chk("midrst_B", B, 16'h0000);
        chk("midrst_op", {10'd0, op_dec}, 16'd0);
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, "post_rst");

        idle();
        step(1'b1, "drain0");
        step(1'b1, "drain1");
        chk("queue_drained", q.size(), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
